// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: frame sequencer for a 5-tap signed convolution datapath.
// Build option: define CONV_RELU_EN to clamp negative results to zero at capture.
module conv_seq_ctrl #(
  parameter  int DW       = 8,
  parameter  int OW       = 19,
  parameter  int NUM_FILT = 4,
  parameter  int SEQ_LEN  = 16,
  localparam int AW       = $clog2(NUM_FILT*5),
  localparam int FW       = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1,
  localparam int PW       = $clog2(SEQ_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 wt_we,
  input  logic [AW-1:0]        wt_addr,
  input  logic signed [DW-1:0] wt_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  output logic                 conv_en,
  output logic signed [DW-1:0] conv_x1,
  output logic signed [DW-1:0] conv_x2,
  output logic signed [DW-1:0] conv_x3,
  output logic signed [DW-1:0] conv_x4,
  output logic signed [DW-1:0] conv_x5,
  output logic signed [DW-1:0] conv_w1,
  output logic signed [DW-1:0] conv_w2,
  output logic signed [DW-1:0] conv_w3,
  output logic signed [DW-1:0] conv_w4,
  output logic signed [DW-1:0] conv_w5,
  input  logic signed [OW-1:0] conv_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [OW-1:0] m_data,
  output logic [FW-1:0]        m_filt,
  output logic [PW-1:0]        m_pos
);

  typedef enum logic [2:0] {IDLE, FILL, COMPUTE, OUTPUT, SHIFT, DONE} state_t;

  localparam int              NW        = NUM_FILT * 5;
  localparam logic [AW:0]     NW_L      = (AW+1)'(NW);
  localparam logic [FW-1:0]   LAST_FILT = FW'(NUM_FILT - 1);
  localparam logic [PW-1:0]   LAST_POS  = PW'(SEQ_LEN - 5);

  state_t               state;
  logic signed [DW-1:0] win  [5];
  logic signed [DW-1:0] bank [NW];
  logic [2:0]           fill_cnt;
  logic [FW-1:0]        filt;
  logic [PW-1:0]        pos;
  logic [AW-1:0]        wbase;
  logic signed [OW-1:0] cap;
  logic                 s_fire;

  assign s_fire = s_valid & s_ready;

  // win[0] is the oldest sample, win[4] the newest.
  assign conv_x1 = win[0];
  assign conv_x2 = win[1];
  assign conv_x3 = win[2];
  assign conv_x4 = win[3];
  assign conv_x5 = win[4];

  assign wbase   = AW'(int'(filt) * 5);
  assign conv_w1 = bank[wbase];
  assign conv_w2 = bank[wbase + AW'(1)];
  assign conv_w3 = bank[wbase + AW'(2)];
  assign conv_w4 = bank[wbase + AW'(3)];
  assign conv_w5 = bank[wbase + AW'(4)];

  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    cap = conv_out;
`ifdef CONV_RELU_EN
    if (conv_out[OW-1]) cap = '0;
`endif
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      s_ready  <= 1'b0;
      conv_en  <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_filt   <= '0;
      m_pos    <= '0;
      fill_cnt <= '0;
      filt     <= '0;
      pos      <= '0;
      for (int i = 0; i < 5; i++) win[i] <= '0;
      // NOTE: the weight bank is built from flops and cleared on reset; weights
      // must be reloaded after any reset, so it cannot be mapped to a RAM.
      for (int i = 0; i < NW; i++) bank[i] <= '0;
    end else begin
      done <= 1'b0;

      if (s_fire) begin
        for (int i = 0; i < 4; i++) win[i] <= win[i+1];
        win[4] <= s_data;
      end

      case (state)
        IDLE: begin
          if (wt_we && ({1'b0, wt_addr} < NW_L)) bank[wt_addr] <= wt_data;
          if (start) begin
            state    <= FILL;
            busy     <= 1'b1;
            s_ready  <= 1'b1;
            fill_cnt <= '0;
            pos      <= '0;
            filt     <= '0;
          end
        end

        FILL: begin
          if (s_fire) begin
            fill_cnt <= fill_cnt + 3'd1;
            if (fill_cnt == 3'd4) begin
              s_ready <= 1'b0;
              conv_en <= 1'b1;
              state   <= COMPUTE;
            end
          end
        end

        COMPUTE: begin
          m_data  <= cap;
          m_filt  <= filt;
          m_pos   <= pos;
          m_valid <= 1'b1;
          conv_en <= 1'b0;
          state   <= OUTPUT;
        end

        OUTPUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (filt < LAST_FILT) begin
              filt    <= filt + FW'(1);
              conv_en <= 1'b1;
              state   <= COMPUTE;
            end else if (pos == LAST_POS) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              filt    <= '0;
              s_ready <= 1'b1;
              state   <= SHIFT;
            end
          end
        end

        SHIFT: begin
          if (s_fire) begin
            pos     <= pos + PW'(1);
            s_ready <= 1'b0;
            conv_en <= 1'b1;
            state   <= COMPUTE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl: a behavioural 5-tap datapath feeds conv_out,
// directed frames push expected results, and a monitor pops them on each handshake.
module tb_conv_seq_ctrl;
  localparam int DW       = 8;
  localparam int OW       = 19;
  localparam int NUM_FILT = 4;
  localparam int SEQ_LEN  = 16;
  localparam int NW       = NUM_FILT * 5;
  localparam int NRES     = (SEQ_LEN - 4) * NUM_FILT;
`ifdef CONV_RELU_EN
  localparam int EXP_NEG  = 0;
`else
  localparam int EXP_NEG  = -15;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 busy, done;
  logic                 wt_we = 1'b0;
  logic [4:0]           wt_addr = '0;
  logic signed [DW-1:0] wt_data = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] s_data = '0;
  logic                 conv_en;
  logic signed [DW-1:0] conv_x1, conv_x2, conv_x3, conv_x4, conv_x5;
  logic signed [DW-1:0] conv_w1, conv_w2, conv_w3, conv_w4, conv_w5;
  logic signed [OW-1:0] conv_out;
  logic                 m_valid;
  logic                 m_ready = 1'b1;
  logic signed [OW-1:0] m_data;
  logic [1:0]           m_filt;
  logic [3:0]           m_pos;

  conv_seq_ctrl #(.DW(DW), .OW(OW), .NUM_FILT(NUM_FILT), .SEQ_LEN(SEQ_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .conv_en(conv_en),
    .conv_x1(conv_x1), .conv_x2(conv_x2), .conv_x3(conv_x3), .conv_x4(conv_x4), .conv_x5(conv_x5),
    .conv_w1(conv_w1), .conv_w2(conv_w2), .conv_w3(conv_w3), .conv_w4(conv_w4), .conv_w5(conv_w5),
    .conv_out(conv_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_filt(m_filt), .m_pos(m_pos)
  );

  always #5 clk = ~clk;

  // Stand-in for the external combinational datapath.
  always_comb
    conv_out = OW'(int'(conv_x1) * int'(conv_w1) + int'(conv_x2) * int'(conv_w2) +
                   int'(conv_x3) * int'(conv_w3) + int'(conv_x4) * int'(conv_w4) +
                   int'(conv_x5) * int'(conv_w5));

  typedef struct { int data; int filt; int pos; } res_t;
  res_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int wts  [NW];
  int samp [SEQ_LEN];

  int acc_cnt = 0, en_cnt = 0, done_cnt = 0;
  int f_first [NUM_FILT];
  int f_last  [NUM_FILT];
  bit prev_stall = 1'b0;
  int hold_data, hold_filt, hold_pos;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted result and checks hold-while-stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (s_valid && s_ready) acc_cnt++;
      if (conv_en) en_cnt++;
      if (done) done_cnt++;
      if (prev_stall) begin
        check("hold_valid", int'(m_valid), 1);
        check("hold_data", int'(m_data), hold_data);
        check("hold_filt", int'(m_filt), hold_filt);
        check("hold_pos", int'(m_pos), hold_pos);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 0, 1);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("res_data", int'(m_data), e.data);
          check("res_filt", int'(m_filt), e.filt);
          check("res_pos", int'(m_pos), e.pos);
        end
        f_last[m_filt] = int'(m_data);
        if (m_pos == 4'd0) f_first[m_filt] = int'(m_data);
      end
      prev_stall = m_valid && !m_ready;
      hold_data  = int'(m_data);
      hold_filt  = int'(m_filt);
      hold_pos   = int'(m_pos);
    end
  end

  task automatic build_expected();
    for (int p = 0; p <= SEQ_LEN - 5; p++)
      for (int f = 0; f < NUM_FILT; f++) begin
        res_t r;
        int s = 0;
        for (int k = 0; k < 5; k++) s += samp[p+k] * wts[f*5+k];
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        r.data = s; r.filt = f; r.pos = p;
        exp_q.push_back(r);
      end
  endtask

  task automatic load_weights();
    for (int a = 0; a < NW; a++) begin
      @(posedge clk); #1;
      wt_we = 1'b1; wt_addr = 5'(a); wt_data = DW'(wts[a]);
    end
    @(posedge clk); #1;
    wt_addr = 5'd25; wt_data = 8'sd55;
    @(posedge clk); #1;
    wt_we = 1'b0;
  endtask

  task automatic run_frame(input bit gaps, input bit rpat, input bit intrude, input bit abort);
    int a0, e0, d0;
    bit frame_end;
    a0 = acc_cnt; e0 = en_cnt; d0 = done_cnt; frame_end = 1'b0;
    build_expected();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    fork
      begin : feed
        int idx = 0;
        while (!frame_end) begin
          @(negedge clk);
          if (s_valid && s_ready) idx++;
          @(posedge clk); #1;
          if (idx < SEQ_LEN && gaps && $urandom_range(0, 2) == 0) s_valid = 1'b0;
          else begin
            s_valid = 1'b1;
            if (idx < SEQ_LEN) s_data = DW'(samp[idx]);
            else s_data = 8'sd85;
          end
        end
        s_valid = 1'b0;
      end
      begin : rdy
        int k = 0;
        while (!frame_end) begin
          @(posedge clk); #1;
          m_ready = rpat ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
          k++;
        end
        m_ready = 1'b1;
      end
      begin : intr
        if (intrude) begin
          repeat (40) @(posedge clk);
          #1;
          check("intrude_busy", int'(busy), 1);
          start = 1'b1; wt_we = 1'b1; wt_addr = 5'd0; wt_data = 8'sd99;
          @(posedge clk); #1;
          start = 1'b0; wt_we = 1'b0;
        end
      end
      begin : watch
        int cyc = 0;
        bit hit = 1'b0;
        while (cyc < 4000 && !hit) begin
          @(negedge clk);
          cyc++;
          if (abort) begin
            if (m_valid && m_pos == 4'd3) hit = 1'b1;
          end else if (done) hit = 1'b1;
        end
        if (!hit) check("frame_timeout", 0, 1);
        if (abort && hit) begin
          #1 rst_n = 1'b0;
          #1;
          check("abort_m_valid", int'(m_valid), 0);
          check("abort_busy", int'(busy), 0);
          check("abort_s_ready", int'(s_ready), 0);
        end
        frame_end = 1'b1;
      end
    join
    if (!abort) begin
      check("samples_taken", acc_cnt - a0, SEQ_LEN);
      check("conv_en_cycles", en_cnt - e0, NRES);
      check("sb_left", exp_q.size(), 0);
      repeat (30) @(negedge clk);
      check("done_pulses", done_cnt - d0, 1);
      check("idle_busy", int'(busy), 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_conv_en", int'(conv_en), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_m_filt", int'(m_filt), 0);
    check("rst_m_pos", int'(m_pos), 0);
    check("rst_x5", int'(conv_x5), 0);
    check("rst_w1", int'(conv_w1), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Frame 1: filter 0 all ones, ramp 1..16, no stalls.
    for (int i = 0; i < NW; i++) wts[i] = (i < 5) ? 1 : 0;
    for (int i = 0; i < SEQ_LEN; i++) samp[i] = i + 1;
    load_weights();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("f0_first", f_first[0], 15);
    check("f0_last", f_last[0], 70);
    check("f1_last", f_last[1], 0);

    // Frame 2: same data, gapped samples, 1-0-0-1 ready, mid-frame start/weight write.
    run_frame(1'b1, 1'b1, 1'b1, 1'b0);
    check("f0_last_stall", f_last[0], 70);

    // Frame 3: full-scale negative product on filter 2.
    for (int i = 0; i < NW; i++) wts[i] = (i >= 10 && i < 15) ? -128 : 0;
    for (int i = 0; i < SEQ_LEN; i++) samp[i] = -128;
    load_weights();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("f2_full_first", f_first[2], 81920);
    check("f2_full_last", f_last[2], 81920);

    // Frame 4: negative result at the first position.
    for (int i = 0; i < NW; i++) wts[i] = (i < 5) ? -1 : 0;
    for (int i = 0; i < SEQ_LEN; i++) samp[i] = i + 1;
    load_weights();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("f0_neg_first", f_first[0], EXP_NEG);

    // Frame 5: reset while presenting position 3, then a frame with cleared weights.
    for (int i = 0; i < NW; i++) wts[i] = (i < 5) ? 1 : 0;
    load_weights();
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_w1", int'(conv_w1), 0);
    check("post_rst_w5", int'(conv_w5), 0);
    check("post_rst_x5", int'(conv_x5), 0);
    check("post_rst_m_data", int'(m_data), 0);
    for (int i = 0; i < NW; i++) wts[i] = 0;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("cleared_f0_last", f_last[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Sequencer for the combinational 5-tap signed convolution datapath (8-bit samples and weights, 19-bit sum). It accepts an ECG sample stream, keeps a 5-sample sliding window, and holds a weight bank of NUM_FILT filters. For every window position it runs the datapath once per filter and returns each 19-bit result on a valid/ready output stream. It sits between the sample source and the downstream pooling/activation stage.

Parameters:
DW, 8, sample and weight width (signed)
OW, 19, datapath result width (signed)
NUM_FILT, 4, filters applied per window position
SEQ_LEN, 16, samples per frame (>=5)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of frame
wt_we  in  1  weight write strobe
wt_addr  in  $clog2(NUM_FILT*5)  filter*5 + tap (tap 0..4)
wt_data  in  DW  signed weight
s_valid  in  1  sample valid
s_ready  out  1  sample accept
s_data  in  DW  signed sample
conv_en  out  1  datapath enable
conv_x1..conv_x5  out  DW each  window taps; x1 oldest, x5 newest
conv_w1..conv_w5  out  DW each  weights of the current filter, taps 0..4
conv_out  in  OW  datapath result (combinational from conv_x/conv_w)
m_valid  out  1  result valid
m_ready  in  1  result accept
m_data  out  OW  registered result
m_filt  out  $clog2(NUM_FILT)  filter index of m_data
m_pos  out  $clog2(SEQ_LEN)  window position of m_data (0 = samples 0..4)

Behaviour:
- Reset: state IDLE; busy, done, s_ready, conv_en, m_valid = 0; m_data, m_filt, m_pos, window, all weights = 0.
- States: IDLE, FILL, COMPUTE, OUTPUT, SHIFT, DONE.
- IDLE: wt_we writes the weight at wt_addr; addresses >= NUM_FILT*5 are ignored. start -> FILL; fill count = 0, pos = 0, filt = 0; busy = 1 next cycle.
- wt_we outside IDLE is ignored. start while busy is ignored.
- FILL: s_ready = 1; each s_valid&s_ready shifts s_data into x5 (x5->x4->...->x1). After the 5th accepted sample -> COMPUTE.
- COMPUTE (1 cycle): conv_en = 1; conv_w* = bank[filt]; conv_out is registered into m_data, with m_filt = filt and m_pos = pos -> OUTPUT. conv_en = 0 in every other state. conv_x* always reflect the window.
- OUTPUT: m_valid = 1; m_data/m_filt/m_pos stay stable until m_valid&m_ready.
  - On handshake, if filt < NUM_FILT-1: filt++ -> COMPUTE.
  - Else if pos == SEQ_LEN-5: -> DONE.
  - Else: filt = 0 -> SHIFT.
- SHIFT: s_ready = 1; one accepted sample shifts the window; pos++ -> COMPUTE.
- DONE: done = 1 for one cycle; busy = 0 -> IDLE.
- Throughput: at most one result every 2 cycles. Results per frame = (SEQ_LEN-4)*NUM_FILT. Samples consumed = SEQ_LEN exactly.
- s_ready is never high in COMPUTE/OUTPUT/DONE/IDLE. No sample is dropped or double-consumed under any s_valid pattern.
- Arithmetic: the controller does not modify the datapath result. The full-scale value 5*(-128*-128) = 81920 fits OW.
- Asynchronous reset mid-frame aborts immediately to reset values. The weight bank is cleared and must be reloaded.

Optional Feature:
CONV_RELU_EN: when defined, a negative conv_out is captured as 0 in COMPUTE (ReLU), so m_data is always >= 0. When undefined, m_data is the raw signed conv_out. Handshake and timing are identical in both builds.

Test Plan:
- Load filter 0 weights {1,1,1,1,1} and filters 1-3 weights 0; start; stream samples 1..16 with s_valid held high -> 48 results. Filter 0 results are 15, 20, 25, ... 70 at m_pos 0..11; other filters give 0. done pulses once; exactly 16 samples are accepted.
- Same frame with m_ready toggled 1-0-0-1 and s_valid gapped randomly -> identical result sequence; m_data/m_filt/m_pos stay stable while m_valid=1 and m_ready=0.
- Filter 2 weights all -128, samples all -128 -> filter 2 results = 81920; conv_en high exactly 48 cycles per frame.
- Filter 0 weights all -1, samples 1..5 at the first position -> m_data = -15 without CONV_RELU_EN and 0 with it.
- Assert rst_n low during OUTPUT at pos 3 -> m_valid/busy drop asynchronously; after release, weights read 0 and a new start runs a full frame.
- wt_we pulse to filter 0 tap 0 while busy, and start pulse mid-frame -> both ignored; results are unchanged and no extra frame runs.
